// File: rtl/core_tick_scheduler.sv
// core_tick_scheduler: per-core timestep sequencer (swap -> drain -> leak sweep -> done); ports: clk/rst, tick_in, decoder_empty/controller_idle in, core_enable/decoder_swap out, leak_valid/leak_addr/leak_ready handshake, tick_done/busy/tick_count/tick_overrun status
module core_tick_scheduler #(
  parameter int NUM_NEURONS  = 256,
  parameter int DRAIN_SETTLE = 2,
  parameter int TICK_WIDTH   = 16,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  decoder_empty,
  input  logic                  controller_idle,
  output logic                  core_enable,
  output logic                  decoder_swap,
  output logic                  leak_valid,
  output logic [AW-1:0]         leak_addr,
  input  logic                  leak_ready,
  output logic                  tick_done,
  output logic                  busy,
  output logic [TICK_WIDTH-1:0] tick_count,
  output logic                  tick_overrun
);
  localparam int QW = $clog2(DRAIN_SETTLE + 1);
  typedef enum logic [2:0] {IDLE, SWAP, DRAIN, LEAK, DONE} state_t;
  state_t state, state_n;
  logic [QW-1:0] quiet_cnt;
  logic quiet, drained, accept, leak_last;
  logic core_enable_n, decoder_swap_n, leak_valid_n, tick_done_n, busy_n;
  assign quiet     = decoder_empty && controller_idle;
  assign drained   = quiet && (quiet_cnt + QW'(1) == QW'(DRAIN_SETTLE));
  assign accept    = leak_valid && leak_ready;
  assign leak_last = leak_addr == AW'(NUM_NEURONS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      core_enable  <= 1'b0;
      decoder_swap <= 1'b0;
      leak_valid   <= 1'b0;
      tick_done    <= 1'b0;
      busy         <= 1'b0;
      quiet_cnt    <= '0;
      leak_addr    <= '0;
      tick_count   <= '0;
      tick_overrun <= 1'b0;
    end else begin
      state        <= state_n;
      core_enable  <= core_enable_n;
      decoder_swap <= decoder_swap_n;
      leak_valid   <= leak_valid_n;
      tick_done    <= tick_done_n;
      busy         <= busy_n;
      quiet_cnt    <= (state == DRAIN && quiet && !drained) ? quiet_cnt + QW'(1) : '0;
      leak_addr    <= (state != LEAK) ? '0 : leak_addr + AW'(accept && !leak_last);
      tick_count   <= tick_count + TICK_WIDTH'(state == IDLE && tick_in);
      tick_overrun <= tick_overrun | (state != IDLE && tick_in);
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = tick_in ? SWAP : IDLE;
      SWAP:    state_n = DRAIN;
      DRAIN:   state_n = drained ? LEAK : DRAIN;
      LEAK:    state_n = (accept && leak_last) ? DONE : LEAK;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are decoded from the next state so each strobe is a flop aligned with its state
  always_comb begin
    core_enable_n  = state_n == DRAIN;
    decoder_swap_n = state_n == SWAP;
    leak_valid_n   = state_n == LEAK;
    tick_done_n    = state_n == DONE;
    busy_n         = state_n != IDLE;
  end
endmodule

// File: tb/tb_core_tick_scheduler.sv
// tb_core_tick_scheduler: scoreboard bench for core_tick_scheduler with NUM_NEURONS=4, DRAIN_SETTLE=2
module tb_core_tick_scheduler;
  logic clk = 1'b0;
  logic rst, tick_in, decoder_empty, controller_idle, leak_ready;
  logic core_enable, decoder_swap, leak_valid, tick_done, busy, tick_overrun;
  logic [1:0] leak_addr;
  logic [15:0] tick_count;
  typedef struct {int c; string t; int v;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  core_tick_scheduler #(.NUM_NEURONS(4), .DRAIN_SETTLE(2), .TICK_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .decoder_empty(decoder_empty),
    .controller_idle(controller_idle), .core_enable(core_enable), .decoder_swap(decoder_swap),
    .leak_valid(leak_valid), .leak_addr(leak_addr), .leak_ready(leak_ready),
    .tick_done(tick_done), .busy(busy), .tick_count(tick_count), .tick_overrun(tick_overrun)
  );
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask
  function automatic int obs(input string t);
    case (t)
      "swap": return int'(decoder_swap);
      "en":   return int'(core_enable);
      "lv":   return int'(leak_valid);
      "la":   return int'(leak_addr);
      "done": return int'(tick_done);
      "busy": return int'(busy);
      "cnt":  return int'(tick_count);
      "ovr":  return int'(tick_overrun);
      default: return -1;
    endcase
  endfunction
  function automatic void push(input int c, input string t, input int v);
    exp_t e;
    e.c = c; e.t = t; e.v = v;
    q.push_back(e);
  endfunction
  task automatic run(input int s, input int ncyc);
    exp_t e;
    rst = 1'b1; tick_in = 1'b0; decoder_empty = 1'b1; controller_idle = 1'b1; leak_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < ncyc; c++) begin
      rst             = (s == 5 && c == 5);
      tick_in         = (c == 0) || (s == 4 && (c == 5 || c == 8 || c == 9));
      decoder_empty   = !(s == 1 && c >= 2 && c <= 5);
      controller_idle = !(s == 2 && c == 3);
      leak_ready      = !(s == 3 && c >= 6 && c <= 8);
      @(negedge clk);
      while (q.size() > 0 && q[0].c == c) begin
        e = q.pop_front();
        chk($sformatf("s%0d.%s@%0d", s, e.t, c), obs(e.t), e.v);
      end
      @(posedge clk);
      #1;
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("s%0d.%s@%0d_unreached", s, e.t, e.c), -1, e.v);
    end
  endtask
  initial begin
    push(0, "busy", 0); push(0, "cnt", 0); push(0, "ovr", 0); push(0, "swap", 0); push(0, "la", 0);
    push(1, "swap", 1); push(1, "busy", 1); push(1, "cnt", 1); push(1, "en", 0);
    push(2, "en", 1); push(2, "swap", 0);
    push(3, "en", 1); push(3, "lv", 0);
    push(4, "en", 0); push(4, "lv", 1); push(4, "la", 0);
    push(5, "la", 1); push(6, "la", 2); push(7, "la", 3); push(7, "done", 0);
    push(8, "done", 1); push(8, "lv", 0); push(8, "busy", 1);
    push(9, "busy", 0); push(9, "done", 0); push(9, "cnt", 1);
    run(0, 10);
    push(7, "en", 1); push(7, "lv", 0);
    push(8, "en", 0); push(8, "lv", 1); push(8, "la", 0);
    push(11, "la", 3); push(11, "done", 0);
    push(12, "done", 1); push(13, "busy", 0);
    run(1, 14);
    push(4, "en", 1); push(5, "en", 1); push(5, "lv", 0);
    push(6, "lv", 1); push(6, "la", 0); push(6, "en", 0);
    push(9, "done", 0); push(10, "done", 1);
    run(2, 12);
    for (int c = 6; c <= 8; c++) begin
      push(c, "la", 2); push(c, "lv", 1); push(c, "done", 0);
    end
    push(9, "la", 2); push(10, "la", 3); push(10, "done", 0);
    push(11, "done", 1); push(12, "busy", 0);
    run(3, 13);
    push(5, "ovr", 0); push(5, "cnt", 1);
    push(6, "ovr", 1); push(6, "cnt", 1); push(6, "la", 2);
    push(8, "done", 1); push(8, "ovr", 1);
    push(9, "busy", 0); push(9, "swap", 0); push(9, "cnt", 1);
    push(10, "swap", 1); push(10, "cnt", 2); push(10, "ovr", 1);
    push(11, "en", 1);
    run(4, 12);
    push(5, "lv", 1); push(5, "la", 1); push(5, "cnt", 1);
    push(6, "lv", 0); push(6, "la", 0); push(6, "busy", 0); push(6, "cnt", 0);
    push(6, "ovr", 0); push(6, "en", 0); push(6, "swap", 0);
    for (int c = 6; c <= 11; c++) push(c, "done", 0);
    push(11, "busy", 0);
    run(5, 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
